// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply/divide for the execute stage.
// One operation at a time. Fixed latency: start accepted at E0, result and a
// one-cycle write pulse appear after E16, idle again after E17.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start, op       request and operation (00 MUL, 01 MULH, 10 DIVU, 11 REMU)
//   a, b, dest      operands and destination register index
//   busy            operation in progress (RUN or DONE)
//   done, we        one-cycle completion / register file write enable
//   wr_rd, result   destination index and result, held until next completion
module mul_div_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       dest,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [2:0]       wr_rd,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [2:0]         dest_q, dest_d;
  // opnd holds the multiplicand (mul) or the divisor (div)
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // acc: product high half (mul) or partial remainder (div)
  logic [WIDTH-1:0]   acc_q, acc_d;
  // lo: multiplier shifting out / product low half (mul), dividend / quotient (div)
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2:0]         wr_rd_q, wr_rd_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     mul_pick;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;

  // Next-state, datapath iteration and output staging
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dest_d   = dest_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    wr_rd_d  = wr_rd_q;
    result_d = result_q;

    // Shift-add step: the carry out of the add becomes the new top bit
    mul_sum  = {1'b0, acc_q} + {1'b0, opnd_q};
    mul_pick = lo_q[0] ? mul_sum : {1'b0, acc_q};

    // Restoring step: WIDTH+1 bits so the shifted remainder cannot overflow;
    // a zero divisor always "fits", giving all-ones quotient and remainder = a
    div_trial = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opnd_q});

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          op_d    = op;
          dest_d  = dest;
          cnt_d   = '0;
          acc_d   = '0;
          if (op[1]) begin
            lo_d   = a;
            opnd_d = b;
          end else begin
            lo_d   = b;
            opnd_d = a;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[1]) begin
          acc_d = div_ge ? WIDTH'(div_trial - {1'b0, opnd_q}) : div_trial[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_pick[WIDTH:1];
          lo_d  = {mul_pick[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          cnt_d   = '0;
          wr_rd_d = dest_q;
          unique case (op_q)
            2'b00:   result_d = lo_d;
            2'b01:   result_d = acc_d;
            2'b10:   result_d = lo_d;
            default: result_d = acc_d;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dest_q   <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_rd_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_rd_q  <= wr_rd_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we     = done_q;
  assign wr_rd  = wr_rd_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + small random bench for mul_div_unit with an expected-result queue.
module tb_mul_div_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [2:0]   dest_i = '0;
  logic         busy, done, we;
  logic [2:0]   wr_rd;
  logic [W-1:0] result;

  typedef struct packed {
    logic [2:0]   rd;
    logic [W-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .dest   (dest_i),
    .busy   (busy),
    .done   (done),
    .we     (we),
    .wr_rd  (wr_rd),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = 32'(x) * 32'(y);
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (y == '0) ? {W{1'b1}} : W'(x / y);
      default: return (y == '0) ? x : W'(x % y);
    endcase
  endfunction

  // Drive one start pulse (sampled at the following posedge) and log the expectation
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2:0] d, input logic [W-1:0] expv, input bit push);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    op_i   = o;
    a_i    = x;
    b_i    = y;
    dest_i = d;
    @(posedge clk);
    #1 start = 1'b0;
    if (push) begin
      e.rd  = d;
      e.res = expv;
      exp_q.push_back(e);
    end
  endtask

  // Wait for completion after an issue; optionally pulse a competing start mid-run
  task automatic wait_done(input string tag, input int inject_cyc);
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   seen = 0;
    exp_t e;
    e = '0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (inject_cyc > 0 && cyc == inject_cyc) begin
        start  = 1'b1;
        op_i   = 2'b10;
        a_i    = 16'd9;
        b_i    = 16'd3;
        dest_i = 3'd5;
      end else if (inject_cyc > 0 && cyc == inject_cyc + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk({tag, "_result"}, 32'(result), 32'(e.res));
        chk({tag, "_wr_rd"}, 32'(wr_rd), 32'(e.rd));
        chk({tag, "_we"}, 32'(we), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'd17);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      @(negedge clk);
      chk({tag, "_done_width"}, 32'({done, we}), 32'd0);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      chk({tag, "_result_hold"}, 32'(result), 32'(e.res));
    end
  endtask

  task automatic no_done(input string tag, input int n);
    int cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done || we) cnt++;
    end
    chk(tag, 32'(cnt), 32'd0);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_wr_rd", 32'(wr_rd), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(2'b00, 16'h0003, 16'h0005, 3'd3, 16'h000F, 1);
    wait_done("mul_3x5", 0);

    issue(2'b01, 16'hFFFF, 16'hFFFF, 3'd4, 16'hFFFE, 1);
    wait_done("mulh_ffff", 0);
    issue(2'b00, 16'hFFFF, 16'hFFFF, 3'd5, 16'h0001, 1);
    wait_done("mul_ffff", 0);

    issue(2'b10, 16'h0064, 16'h0007, 3'd6, 16'h000E, 1);
    wait_done("divu_100_7", 0);
    issue(2'b11, 16'h0064, 16'h0007, 3'd7, 16'h0002, 1);
    wait_done("remu_100_7", 0);

    issue(2'b10, 16'h1234, 16'h0000, 3'd2, 16'hFFFF, 1);
    wait_done("divu_by0", 0);
    issue(2'b11, 16'h1234, 16'h0000, 3'd0, 16'h1234, 1);
    wait_done("remu_by0_r0", 0);

    // Competing start during RUN must be dropped
    issue(2'b00, 16'h0002, 16'h0003, 3'd1, 16'h0006, 1);
    wait_done("mul_busy_ignore", 5);
    no_done("no_queued_op", 20);
    issue(2'b10, 16'h0009, 16'h0003, 3'd5, 16'h0003, 1);
    wait_done("divu_after_busy", 0);

    // Asynchronous reset in the middle of an operation
    issue(2'b00, 16'h00AB, 16'h0101, 3'd3, 16'hABAB, 0);
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_done", 32'({done, we}), 32'd0);
    chk("abort_wr_rd", 32'(wr_rd), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    no_done("no_we_after_abort", 20);
    issue(2'b00, 16'h0004, 16'h0004, 3'd2, 16'h0010, 1);
    wait_done("mul_4x4_post_rst", 0);

    // A few random operations against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom_range(0, 300));
      issue(ro, ra, rb, 3'(i), model(ro, ra, rb), 1);
      wait_done("rand", 0);
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 16-bit unsigned multiply/divide unit in the execute path of the Simple RISC CPU. It consumes the two source operands read from the register file and produces a write-back triple (enable, destination index, data) that drives the register file write port directly. It completes one operation at a time over a fixed 17-cycle latency, with a start/busy/done handshake toward the control unit.

## Interface

**Parameters**
- `WIDTH`, default 16: operand and result width. The iteration count equals `WIDTH`.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a new operation. Sampled only in IDLE.
- `op`, input, 2: operation select. 00 MUL (low half of the product), 01 MULH (high half), 10 DIVU (quotient), 11 REMU (remainder).
- `a`, input, WIDTH: operand 1, from the register file `rd1`.
- `b`, input, WIDTH: operand 2, from the register file `rd2`.
- `dest`, input, 3: destination register index.
- `busy`, output, 1: high while an operation is in progress (RUN or DONE).
- `done`, output, 1: one-cycle completion pulse.
- `we`, output, 1: register file write enable. Identical to `done`.
- `wr_rd`, output, 3: destination index for the register file `rd`.
- `result`, output, WIDTH: result for the register file `wd`. Holds the last completed value.

## Operation

- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1 at a clock edge. `op`, `a`, `b` and `dest` are latched on that edge, and the iteration counter is cleared.
  - RUN executes one iteration per edge. After 16 iterations (counter reaches WIDTH−1), RUN → DONE.
  - DONE → IDLE unconditionally on the next edge.
- **Start while busy:** `start` in RUN or DONE is ignored. The latched operands are unaffected and no request is queued.
- **Multiply (MUL, MULH):**
  - Shift-add over a 2·WIDTH product register. Each iteration adds the latched `a` when the current multiplier bit is 1.
  - MUL returns product[15:0]. MULH returns product[31:16].
  - All arithmetic is unsigned and the full 32-bit product is exact.
- **Divide (DIVU, REMU):**
  - Restoring division, one quotient bit per iteration, MSB first.
  - The WIDTH+1-bit partial remainder prevents overflow on compare and subtract.
- **Divide by zero:** there is no special path and no extra cycles. The restoring algorithm itself yields DIVU = 0xFFFF and REMU = `a`.
- **Result update:** `result` and `wr_rd` are updated on the RUN → DONE edge and held until the next completion.
- **Register 0:** `dest`=0 is legal. Register 0 is written like any other register.
- **Reset** (asynchronous, `reset`=0):
  - State goes to IDLE immediately. `busy`, `done` and `we` are 0. `result` = 0x0000, `wr_rd` = 0.
  - Counter and internal datapath registers are cleared.
  - Reset asserted in the middle of an operation aborts it. No write pulse is ever issued for the aborted operation.

## Timing

- `start` is sampled at edge E0.
- `busy` goes high after E0.
- RUN iterations occur at edges E1 through E16.
- `done` and `we` are high for exactly the cycle between E16 and E17, with `result` and `wr_rd` valid during that cycle.
- `busy` goes low after E17. The earliest next accepted `start` is at E17+1, which gives a throughput of one operation per 18 cycles.
- The register file captures `wd` at E17, because its write is synchronous on `we`.
- `result` remains stable after `done` falls.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

1. **MUL:** reset, then MUL with `a`=0x0003, `b`=0x0005, `dest`=3 → `done`/`we` high for exactly one cycle, 17 cycles after start, with `result`=0x000F and `wr_rd`=3. `busy` is high for 17 cycles.
2. **MULH and MUL on 0xFFFF × 0xFFFF:** MULH gives `result`=0xFFFE; MUL on the same operands gives 0x0001. Product is 0xFFFE0001.
3. **DIVU and REMU on 100 / 7:** `a`=0x0064, `b`=0x0007 → DIVU `result`=0x000E, REMU `result`=0x0002.
4. **Divide by zero:** `a`=0x1234, `b`=0x0000 → DIVU `result`=0xFFFF, REMU `result`=0x1234. Latency is still 17 cycles.
5. **Start ignored while busy:** start MUL 2×3 with `dest`=1, then pulse `start` with DIVU 9/3 and `dest`=5 during RUN → exactly one `done`, with `result`=0x0006 and `wr_rd`=1. A new op issued after `busy` falls completes normally.
6. **Reset mid-operation:** drive `reset`=0 asynchronously (off-edge) at the 8th RUN cycle → `busy`=0 immediately and `result`=0x0000. After release, no `we` pulse appears for 20 cycles. A following MUL 4×4 yields 0x0010.
